// File: rtl/mc_fill_rx_pkg.sv
// Shared ring definitions for the read-return receiver: line geometry, error codes,
// reserved destination and receiver state encoding.
package mc_fill_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ORDER   = 2'd1,
    ERR_UNEXP   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // Destination 0 marks an idle bus slot and never addresses a core.
  localparam int DEST_NONE = 0;
  localparam int TIMER_W   = 10;

  function automatic int words_per_line(input int nbwords);
    return 1 << nbwords;
  endfunction

endpackage

// File: rtl/mc_fill_rx_if.sv
// Read-return bus, arm handshake and cache-array write port of one core's fill receiver.
interface mc_fill_rx_if #(
  parameter int SSIZE   = 4,
  parameter int NBWORDS = 3
);
  logic [SSIZE-1:0]   mc_dest;
  logic [NBWORDS-1:0] mc_count;
  logic [31:0]        mc_data;
  logic               arm;
  logic [NBWORDS-1:0] arm_word;
  logic               arm_ready;
  logic               wr_en;
  logic [NBWORDS-1:0] wr_idx;
  logic [31:0]        wr_data;
  logic               crit_valid;
  logic               fill_done;
  logic               fill_ack;
  logic               err;
  logic [1:0]         err_code;

  modport master (
    output mc_dest, mc_count, mc_data, arm, arm_word, fill_ack,
    input  arm_ready, wr_en, wr_idx, wr_data, crit_valid, fill_done, err, err_code
  );

  modport slave (
    input  mc_dest, mc_count, mc_data, arm, arm_word, fill_ack,
    output arm_ready, wr_en, wr_idx, wr_data, crit_valid, fill_done, err, err_code
  );
endinterface

// File: rtl/mc_fill_rx_sat_timer.sv
// 10-bit saturating cycle counter; tc_o flags the enabled cycle whose increment reaches LIMIT.
module sat_timer
  import mc_fill_rx_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TIMER_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/mc_fill_rx.sv
// Per-core fill receiver: captures the line words tagged for this core in order, writes
// them to the cache data array and reports critical word, completion and errors.
module mc_fill_rx
  import mc_fill_rx_pkg::*;
#(
  parameter int CORENUM = 1,
  parameter int SSIZE   = 4,
  parameter int NBWORDS = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  mc_fill_rx_if.slave bus
);

  localparam logic [NBWORDS-1:0] LAST_IDX = NBWORDS'(words_per_line(NBWORDS) - 1);
  localparam logic [SSIZE-1:0]   MY_DEST  = SSIZE'(CORENUM);

  fill_state_e        state_q, state_d;
  logic [NBWORDS-1:0] exp_q, exp_d;
  logic [NBWORDS-1:0] crit_idx_q, crit_idx_d;
  logic               wr_en_q, wr_en_d;
  logic [NBWORDS-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               crit_q, crit_d;
  logic               err_q, err_d;
  err_code_e          err_code_q, err_code_d;
  err_code_e          evt;
  logic               arm_ready;
  logic               my_word;
  logic               timer_clr;
  logic               timer_tc;

  assign arm_ready = (state_q == ST_IDLE);
  assign my_word   = (bus.mc_dest != SSIZE'(DEST_NONE)) && (bus.mc_dest == MY_DEST);

  sat_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (timer_clr),
    .en_i  (state_q == ST_FILL),
    .tc_o  (timer_tc)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    crit_idx_d = crit_idx_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    crit_d     = 1'b0;
    timer_clr  = 1'b0;
    evt        = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        // A word coinciding with the accepted arm still counts as unsolicited.
        if (my_word) evt = ERR_UNEXP;
        if (bus.arm && arm_ready) begin
          state_d    = ST_FILL;
          crit_idx_d = bus.arm_word;
          exp_d      = '0;
          timer_clr  = 1'b1;
        end
      end
      ST_FILL: begin
        if (my_word) begin
          if (bus.mc_count == exp_q) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = bus.mc_count;
            wr_data_d = bus.mc_data;
            exp_d     = exp_q + 1'b1;
            crit_d    = (bus.mc_count == crit_idx_q);
            if (bus.mc_count == LAST_IDX) state_d = ST_DONE;
          end else begin
            evt = ERR_ORDER;
          end
        end
        // Timeout outranks an out-of-order word in the same cycle.
        if (timer_tc) begin
          state_d = ST_IDLE;
          evt     = ERR_TIMEOUT;
        end
      end
      ST_DONE: begin
        if (my_word) evt = ERR_UNEXP;
        if (bus.fill_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d      = err_q || (evt != ERR_NONE);
    err_code_d = err_q ? err_code_q : evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      crit_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      crit_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      crit_idx_q <= crit_idx_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      crit_q     <= crit_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.arm_ready  = arm_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.crit_valid = crit_q;
  assign bus.fill_done  = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_mc_fill_rx.sv
// Bench for mc_fill_rx: directed scenarios with literal expectations plus randomized
// fills, all outputs compared every cycle against a behavioural line-fill model.
module tb_mc_fill_rx;

  localparam int CORENUM = 2;
  localparam int TIMEOUT = 20;
  localparam int NWORDS  = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   running = 0;

  mc_fill_rx_if #(.SSIZE(4), .NBWORDS(3)) bus ();

  mc_fill_rx #(
    .CORENUM (CORENUM),
    .SSIZE   (4),
    .NBWORDS (3),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_FILL, PH_WAIT_ACK} phase_e;
  phase_e      m_phase = PH_IDLE;
  int          m_next = 0;
  int          m_age = 0;
  int          m_crit = 0;
  int          m_code;
  bit          m_mine;
  logic        e_wr_en = 0;
  logic [2:0]  e_wr_idx = 0;
  logic [31:0] e_wr_data = 0;
  logic        e_crit = 0;
  logic        e_err = 0;
  logic [1:0]  e_code = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_next = 0; m_age = 0; m_crit = 0;
      e_wr_en = 0; e_wr_idx = 0; e_wr_data = 0; e_crit = 0; e_err = 0; e_code = 0;
    end else begin
      m_code  = 0;
      m_mine  = (int'(bus.mc_dest) == CORENUM);
      e_wr_en = 0;
      e_crit  = 0;
      case (m_phase)
        PH_IDLE: begin
          if (m_mine) m_code = 2;
          if (bus.arm) begin
            m_phase = PH_FILL; m_crit = int'(bus.arm_word); m_next = 0; m_age = 0;
          end
        end
        PH_FILL: begin
          m_age++;
          if (m_mine && int'(bus.mc_count) == m_next) begin
            e_wr_en = 1; e_wr_idx = bus.mc_count; e_wr_data = bus.mc_data;
            e_crit = (m_next == m_crit);
            if (m_next == NWORDS - 1) m_phase = PH_WAIT_ACK;
            m_next++;
          end else if (m_mine) begin
            m_code = 1;
          end
          if (m_age == TIMEOUT) begin
            m_code = 3; m_phase = PH_IDLE;
          end
        end
        PH_WAIT_ACK: begin
          if (m_mine) m_code = 2;
          if (bus.fill_ack) m_phase = PH_IDLE;
        end
        default: m_phase = PH_IDLE;
      endcase
      if (!e_err && m_code != 0) begin
        e_err = 1; e_code = 2'(m_code);
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      check("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
        check("wr_idx", 32'(bus.wr_idx), 32'(e_wr_idx));
        check("wr_data", bus.wr_data, e_wr_data);
      end
      check("crit_valid", 32'(bus.crit_valid), 32'(e_crit));
      check("arm_ready", 32'(bus.arm_ready), 32'(m_phase == PH_IDLE));
      check("fill_done", 32'(bus.fill_done), 32'(m_phase == PH_WAIT_ACK));
      check("err", 32'(bus.err), 32'(e_err));
      check("err_code", 32'(bus.err_code), 32'(e_code));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mc_dest = '0; bus.mc_count = '0; bus.mc_data = '0;
    bus.arm = 1'b0; bus.arm_word = '0; bus.fill_ack = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] c, input logic [31:0] v);
    bus.mc_dest = d; bus.mc_count = c; bus.mc_data = v;
    cyc();
    bus.mc_dest = '0;
  endtask

  task automatic arm_line(input logic [2:0] w);
    bus.arm = 1'b1; bus.arm_word = w;
    cyc();
    bus.arm = 1'b0;
  endtask

  task automatic ack();
    bus.fill_ack = 1'b1;
    cyc();
    bus.fill_ack = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
  endtask

  function automatic logic [3:0] foreign_dest();
    logic [3:0] d;
    do d = 4'($urandom_range(0, 15)); while (int'(d) == CORENUM);
    return d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  int nsend;
  bit ooo_used;

  initial begin
    rst_n = 1'b0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_arm_ready", 32'(bus.arm_ready), 1);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_fill_done", 32'(bus.fill_done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_err_code", 32'(bus.err_code), 0);
    rst_n   = 1'b1;
    running = 1;
    cyc();

    // In-order burst, critical word 5, data A0..A7.
    arm_line(3'd5);
    cyc();
    for (int i = 0; i < 8; i++) begin
      send(4'd2, 3'(i), 32'hA0 + 32'(i));
      check("burst_wr_en", 32'(bus.wr_en), 1);
      check("burst_wr_idx", 32'(bus.wr_idx), 32'(i));
      check("burst_wr_data", bus.wr_data, 32'hA0 + 32'(i));
      check("burst_crit", 32'(bus.crit_valid), 32'(i == 5));
      check("burst_fill_done", 32'(bus.fill_done), 32'(i == 7));
    end
    check("burst_err", 32'(bus.err), 0);
    ack();
    check("burst_ack_done", 32'(bus.fill_done), 0);
    check("burst_ack_ready", 32'(bus.arm_ready), 1);

    // Foreign traffic interleaved with our burst.
    arm_line(3'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      send(foreign_dest(), 3'($urandom_range(0, 7)), $urandom);
      check("foreign_no_wr", 32'(bus.wr_en), 0);
      send(4'd2, 3'(i), $urandom);
      check("foreign_wr_idx", 32'(bus.wr_idx), 32'(i));
    end
    check("foreign_err", 32'(bus.err), 0);
    ack();

    // Out-of-order word.
    do_reset();
    arm_line(3'd2);
    cyc();
    send(4'd2, 3'd0, 32'h10);
    send(4'd2, 3'd1, 32'h11);
    send(4'd2, 3'd3, 32'h13);
    check("ooo_no_wr", 32'(bus.wr_en), 0);
    check("ooo_err", 32'(bus.err), 1);
    check("ooo_code", 32'(bus.err_code), 1);
    for (int i = 2; i < 8; i++) send(4'd2, 3'(i), 32'h10 + 32'(i));
    check("ooo_done", 32'(bus.fill_done), 1);
    check("ooo_last_idx", 32'(bus.wr_idx), 7);
    ack();

    // Unarmed word in IDLE.
    do_reset();
    send(4'd2, 3'd0, 32'h55);
    check("unarmed_no_wr", 32'(bus.wr_en), 0);
    check("unarmed_code", 32'(bus.err_code), 2);

    // Extra word while waiting for fill_ack.
    do_reset();
    arm_line(3'd7);
    cyc();
    for (int i = 0; i < 8; i++) send(4'd2, 3'(i), $urandom);
    repeat (5) begin
      cyc();
      check("hold_done", 32'(bus.fill_done), 1);
    end
    send(4'd2, 3'd3, 32'h77);
    check("done_extra_no_wr", 32'(bus.wr_en), 0);
    check("done_extra_code", 32'(bus.err_code), 2);
    check("done_extra_hold", 32'(bus.fill_done), 1);
    ack();

    // Timeout after TIMEOUT fill cycles with no words.
    do_reset();
    arm_line(3'd1);
    repeat (TIMEOUT - 1) cyc();
    check("to_pre_err", 32'(bus.err), 0);
    check("to_pre_ready", 32'(bus.arm_ready), 0);
    cyc();
    check("to_err", 32'(bus.err), 1);
    check("to_code", 32'(bus.err_code), 3);
    check("to_ready", 32'(bus.arm_ready), 1);
    check("to_no_done", 32'(bus.fill_done), 0);

    // Reset mid-fill, then the rest of the burst arrives unarmed.
    do_reset();
    arm_line(3'd4);
    cyc();
    for (int i = 0; i < 3; i++) send(4'd2, 3'(i), $urandom);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_wr_en", 32'(bus.wr_en), 0);
    check("rmid_ready", 32'(bus.arm_ready), 1);
    check("rmid_err", 32'(bus.err), 0);
    check("rmid_done", 32'(bus.fill_done), 0);
    #1 rst_n = 1'b1;
    cyc();
    for (int i = 3; i < 8; i++) send(4'd2, 3'(i), $urandom);
    check("rmid_after_code", 32'(bus.err_code), 2);

    // Randomized fills checked only by the model.
    for (int ln = 0; ln < 40; ln++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) send(4'd2, 3'($urandom_range(0, 7)), $urandom);
      arm_line(3'($urandom_range(0, 7)));
      repeat ($urandom_range(1, 2)) cyc();
      nsend    = ($urandom_range(0, 9) == 0) ? 4 : 8;
      ooo_used = 0;
      for (int i = 0; i < nsend; i++) begin
        if (!ooo_used && $urandom_range(0, 7) == 0) begin
          ooo_used = 1;
          send(4'd2, 3'((i + 1 + int'($urandom_range(0, 6))) % 8), $urandom);
        end
        send(4'd2, 3'(i), $urandom);
        if (i < nsend - 1 && $urandom_range(0, 1) == 1)
          send(foreign_dest(), 3'($urandom_range(0, 7)), $urandom);
      end
      repeat ($urandom_range(0, 3)) begin
        bus.fill_ack = 1'($urandom_range(0, 1));
        cyc();
      end
      bus.fill_ack = 1'b1;
      for (int k = 0; k < 50 && !bus.arm_ready; k++) cyc();
      bus.fill_ack = 1'b0;
      check("rand_back_to_idle", 32'(bus.arm_ready), 1);
    end

    cyc();
    running = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
